battle_step_ctrl: RTL and testbench
===================================

Name: battle_step_ctrl

Overview:
Initiator side of the BattleFront Start/Done/Ack handshake. On each game tick it starts one BattleFront evaluation and waits for Done. It then latches the two fronts and two damage selects, returns Ack, and issues at most two single-cycle damage strobes (friendly first, then enemy) to the unit health register file. It sits between the game tick timer and BattleFront/unit storage, and includes a watchdog so a hung BattleFront cannot stall the game loop.

Parameters:
DMG_W, 4, width of damage amount
F_DMG, 3, damage applied to the selected friendly unit (dealt by enemies)
E_DMG, 3, damage applied to the selected enemy unit (dealt by friendlies)
TIMEOUT, 64, max cycles allowed in WAIT_DONE or DRAIN before abort; must be >= 2

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  reset
Tick  in  1  request one battle step (single-cycle pulse from game timer)
bf_Start  out  1  Start to BattleFront
bf_Ack  out  1  Ack to BattleFront
bf_Done  in  1  Done from BattleFront
friendlyFront  in  9  BattleFront result
enemyFront  in  9  BattleFront result
unitDamageSelect  in  5  [4]=1: no target; [3:0] friendly index
enemyDamageSelect  in  5  [4]=1: no target; [3:0] enemy index
dmg_valid  out  1  damage strobe, one cycle
dmg_side  out  1  0 = friendly unit, 1 = enemy unit
dmg_index  out  4  unit index to damage
dmg_amount  out  DMG_W  F_DMG or E_DMG
front_f  out  9  latched friendly front
front_e  out  9  latched enemy front
StepDone  out  1  one-cycle pulse at step end (normal or abort)
Timeout  out  1  valid with StepDone: 1 = aborted step
Overrun  out  1  sticky: Tick arrived while busy
Busy  out  1  state != IDLE

Behaviour:
- One clock domain. Reset is synchronous and active-high: clk, rst.
- Reset values: state = IDLE; all 1-bit outputs = 0; dmg_index = 0, dmg_amount = 0, dmg_side = 0; front_f = 0, front_e = 511; watchdog = 0. Reset mid-step returns to IDLE with no strobe issued.
- States: IDLE, START, WAIT_DONE, ACK, DRAIN, APPLY_F, APPLY_E, FINISH, ABORT.
- IDLE: on Tick go to START.
- START: bf_Start = 1 for exactly this cycle; go to WAIT_DONE; clear watchdog.
- WAIT_DONE: on bf_Done = 1, latch friendlyFront, enemyFront and both selects in that cycle, then go to ACK.
- ACK: bf_Ack = 1 for exactly one cycle; go to DRAIN.
- DRAIN: wait for bf_Done = 0, then go to APPLY_F.
- WAIT_DONE and DRAIN each count cycles in the watchdog. When the count reaches TIMEOUT, go to ABORT. The watchdog is cleared on every state entry.
- APPLY_F: if latched unitSel[4] = 0, drive dmg_valid = 1, side = 0, index = unitSel[3:0], amount = F_DMG; otherwise no strobe. Always advance to APPLY_E.
- APPLY_E: same, with side = 1 and amount = E_DMG; go to FINISH.
- FINISH: update front_f/front_e from the latches; StepDone = 1, Timeout = 0; go to IDLE.
- ABORT: StepDone = 1, Timeout = 1; fronts unchanged; no damage; bf_Ack not asserted; go to IDLE.
- Latency with Done returned N cycles after Start: StepDone fires 5 cycles after Done is seen, provided Done drops immediately after Ack.
- Tick outside IDLE is ignored and sets Overrun. Overrun is cleared only by rst.
- bf_Done already high in the IDLE/START cycle is not sampled; only WAIT_DONE samples it.
- bf_Start and bf_Ack are never high together; dmg_valid is never high in the same cycle as bf_Start or bf_Ack.
- dmg_index, dmg_side and dmg_amount hold their last value when dmg_valid = 0.

Optional Feature:
BATTLE_STEP_STATS_EN:
- Defined: adds outputs step_count[15:0] (increments on each normal FINISH, wraps at 65535 -> 0), abort_count[7:0] (saturates at 255) and last_latency[7:0] (cycles from Start to Done seen, saturating at 255). All reset to 0.
- Undefined: these ports and registers are absent.

Decomposition:
- Shared package battle_pkg holds: LOC_W = 9, IDX_W = 4, SEL_W = 5, NO_TARGET bit position = 4, the state encoding typedef, and side constants SIDE_FRIENDLY = 0 / SIDE_ENEMY = 1.
- Sub-module battle_watchdog: counter with clear/enable inputs and an expired output at TIMEOUT.

Test Plan:
- Tick; model returns Done 3 cycles after Start with fronts 474/39 and selects 14/1 -> Ack pulse once; dmg strobes (0,14,3) then (1,1,3); front_f = 474, front_e = 39; StepDone with Timeout = 0.
- Selects 16/16 -> no dmg_valid; StepDone fires; fronts updated to 58/487.
- Done never asserted -> ABORT after 64 cycles in WAIT_DONE; StepDone with Timeout = 1; fronts keep 474/39; no Ack.
- Done held high 70 cycles after Ack -> abort from DRAIN; no damage issued.
- Second Tick during WAIT_DONE -> ignored, Overrun = 1, exactly one Start seen; rst asserted mid-WAIT_DONE -> all outputs back to reset values next cycle.
- With BATTLE_STEP_STATS_EN: 3 normal steps + 1 abort -> step_count = 3, abort_count = 1, last_latency = 3.

Source files
------------

// File: rtl/battle_pkg.sv
// Shared definitions for the battle step controller.
// Holds field widths, the no-target flag position, the controller state
// encoding, damage side constants and the latched BattleFront result struct.
package battle_pkg;
  localparam int LOC_W     = 9;
  localparam int IDX_W     = 4;
  localparam int SEL_W     = 5;
  localparam int NO_TARGET = 4;

  localparam logic SIDE_FRIENDLY = 1'b0;
  localparam logic SIDE_ENEMY    = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_WAIT_DONE, S_ACK, S_DRAIN,
    S_APPLY_F, S_APPLY_E, S_FINISH, S_ABORT
  } state_t;

  // One BattleFront evaluation result, captured when Done is seen.
  typedef struct packed {
    logic [LOC_W-1:0] fFront;
    logic [LOC_W-1:0] eFront;
    logic [SEL_W-1:0] uSel;
    logic [SEL_W-1:0] eSel;
  } bf_result_t;
endpackage

// File: rtl/battle_watchdog.sv
// Cycle watchdog for the battle step controller.
// Ports: clk, rst (sync, active-high), clr (zero the count), en (count this
// cycle), expired (high on the TIMEOUT-th enabled cycle since the last clear).
module battle_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  // The count holds the number of enabled cycles already completed, so the
  // current cycle is the TIMEOUT-th one when it reads TIMEOUT-1.
  assign expired = en && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr)          cnt <= '0;
    else if (en && !expired) cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/battle_step_ctrl.sv
// Initiator side of the BattleFront Start/Done/Ack handshake.
// Per Tick: pulse bf_Start, wait for bf_Done, latch fronts and selects,
// pulse bf_Ack, wait for Done to drop, emit up to two damage strobes
// (friendly then enemy), publish the fronts and pulse StepDone. A watchdog
// aborts the step (StepDone with Timeout) if WAIT_DONE or DRAIN hangs.
// Ports: clk, rst (sync, active-high), Tick, bf_Start/bf_Ack/bf_Done,
//   friendlyFront/enemyFront/unitDamageSelect/enemyDamageSelect (BattleFront
//   results), dmg_valid/dmg_side/dmg_index/dmg_amount (damage strobe),
//   front_f/front_e, StepDone, Timeout, Overrun (sticky), Busy.
// Optional: BATTLE_STEP_STATS_EN adds step_count, abort_count, last_latency.
module battle_step_ctrl
  import battle_pkg::*;
#(
  parameter int DMG_W   = 4,
  parameter int F_DMG   = 3,
  parameter int E_DMG   = 3,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Tick,
  output logic             bf_Start,
  output logic             bf_Ack,
  input  logic             bf_Done,
  input  logic [LOC_W-1:0] friendlyFront,
  input  logic [LOC_W-1:0] enemyFront,
  input  logic [SEL_W-1:0] unitDamageSelect,
  input  logic [SEL_W-1:0] enemyDamageSelect,
  output logic             dmg_valid,
  output logic             dmg_side,
  output logic [IDX_W-1:0] dmg_index,
  output logic [DMG_W-1:0] dmg_amount,
  output logic [LOC_W-1:0] front_f,
  output logic [LOC_W-1:0] front_e,
  output logic             StepDone,
  output logic             Timeout,
  output logic             Overrun,
  output logic             Busy
`ifdef BATTLE_STEP_STATS_EN
  ,
  output logic [15:0]      step_count,
  output logic [7:0]       abort_count,
  output logic [7:0]       last_latency
`endif
);
  state_t     state, nextState;
  bf_result_t res;
  logic       wdExp, wdEn, wdClr;

  // Damage fields are registered copies of the outputs so they hold between
  // strobes while the strobe cycle itself drives the new values directly.
  logic             dmgSideQ;
  logic [IDX_W-1:0] dmgIdxQ;
  logic [DMG_W-1:0] dmgAmtQ;

  assign wdEn  = (state == S_WAIT_DONE) || (state == S_DRAIN);
  assign wdClr = (nextState != state);
  assign Busy  = (state != S_IDLE);

  battle_watchdog #(.TIMEOUT(TIMEOUT)) uWatchdog (
    .clk(clk), .rst(rst), .clr(wdClr), .en(wdEn), .expired(wdExp)
  );

  always_comb begin
    nextState  = state;
    bf_Start   = 1'b0;
    bf_Ack     = 1'b0;
    StepDone   = 1'b0;
    Timeout    = 1'b0;
    dmg_valid  = 1'b0;
    dmg_side   = dmgSideQ;
    dmg_index  = dmgIdxQ;
    dmg_amount = dmgAmtQ;
    case (state)
      S_IDLE:      if (Tick) nextState = S_START;
      S_START: begin
        bf_Start  = 1'b1;
        nextState = S_WAIT_DONE;
      end
      // Done seen on the last allowed cycle still counts as a result.
      S_WAIT_DONE: if (bf_Done)    nextState = S_ACK;
                   else if (wdExp) nextState = S_ABORT;
      S_ACK: begin
        bf_Ack    = 1'b1;
        nextState = S_DRAIN;
      end
      S_DRAIN:     if (!bf_Done)   nextState = S_APPLY_F;
                   else if (wdExp) nextState = S_ABORT;
      S_APPLY_F: begin
        if (!res.uSel[NO_TARGET]) begin
          dmg_valid  = 1'b1;
          dmg_side   = SIDE_FRIENDLY;
          dmg_index  = res.uSel[IDX_W-1:0];
          dmg_amount = DMG_W'(F_DMG);
        end
        nextState = S_APPLY_E;
      end
      S_APPLY_E: begin
        if (!res.eSel[NO_TARGET]) begin
          dmg_valid  = 1'b1;
          dmg_side   = SIDE_ENEMY;
          dmg_index  = res.eSel[IDX_W-1:0];
          dmg_amount = DMG_W'(E_DMG);
        end
        nextState = S_FINISH;
      end
      S_FINISH: begin
        StepDone  = 1'b1;
        nextState = S_IDLE;
      end
      S_ABORT: begin
        StepDone  = 1'b1;
        Timeout   = 1'b1;
        nextState = S_IDLE;
      end
      default:     nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      res      <= '0;
      dmgSideQ <= 1'b0;
      dmgIdxQ  <= '0;
      dmgAmtQ  <= '0;
      front_f  <= '0;
      front_e  <= '1;
      Overrun  <= 1'b0;
    end else begin
      state    <= nextState;
      dmgSideQ <= dmg_side;
      dmgIdxQ  <= dmg_index;
      dmgAmtQ  <= dmg_amount;
      if (state == S_WAIT_DONE && bf_Done)
        res <= '{fFront: friendlyFront, eFront: enemyFront,
                 uSel: unitDamageSelect, eSel: enemyDamageSelect};
      if (state == S_FINISH) begin
        front_f <= res.fFront;
        front_e <= res.eFront;
      end
      if (Tick && state != S_IDLE) Overrun <= 1'b1;
    end
  end

`ifdef BATTLE_STEP_STATS_EN
  // latCnt reads 1 on the first WAIT_DONE cycle, so on the cycle Done is
  // seen it equals the number of cycles since Start.
  logic [7:0] latCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      step_count   <= '0;
      abort_count  <= '0;
      last_latency <= '0;
      latCnt       <= '0;
    end else begin
      if (state == S_FINISH) step_count <= step_count + 16'd1;
      if (state == S_ABORT && abort_count != 8'hFF) abort_count <= abort_count + 8'd1;
      if (state == S_START) latCnt <= 8'd1;
      else if (state == S_WAIT_DONE && latCnt != 8'hFF) latCnt <= latCnt + 8'd1;
      if (state == S_WAIT_DONE && bf_Done) last_latency <= latCnt;
    end
  end
`endif
endmodule

// File: tb/tb_battle_step_ctrl.sv
// Bench for battle_step_ctrl: a cycle timeline is planned up front from the
// handshake rules (when Start, Ack, strobes, StepDone and front updates must
// appear for a given Tick cycle and Done delay), inputs are replayed from it,
// and every cycle's outputs are compared against it, plus literal spot checks.
module tb_battle_step_ctrl;
  localparam int MAXC = 370;
  localparam int TO   = 64;

  logic       clk = 1'b0, rst = 1'b1, Tick = 1'b0, bf_Done = 1'b0;
  logic [8:0] friendlyFront = '0, enemyFront = '0;
  logic [4:0] unitDamageSelect = '0, enemyDamageSelect = '0;
  logic       bf_Start, bf_Ack, dmg_valid, dmg_side, StepDone, Timeout, Overrun, Busy;
  logic [3:0] dmg_index, dmg_amount;
  logic [8:0] front_f, front_e;
`ifdef BATTLE_STEP_STATS_EN
  logic [15:0] step_count;
  logic [7:0]  abort_count, last_latency;
`endif

  battle_step_ctrl dut (
    .clk(clk), .rst(rst), .Tick(Tick), .bf_Start(bf_Start), .bf_Ack(bf_Ack),
    .bf_Done(bf_Done), .friendlyFront(friendlyFront), .enemyFront(enemyFront),
    .unitDamageSelect(unitDamageSelect), .enemyDamageSelect(enemyDamageSelect),
    .dmg_valid(dmg_valid), .dmg_side(dmg_side), .dmg_index(dmg_index),
    .dmg_amount(dmg_amount), .front_f(front_f), .front_e(front_e),
    .StepDone(StepDone), .Timeout(Timeout), .Overrun(Overrun), .Busy(Busy)
`ifdef BATTLE_STEP_STATS_EN
    , .step_count(step_count), .abort_count(abort_count), .last_latency(last_latency)
`endif
  );

  always #5 clk = ~clk;

  // Input timeline
  bit         iRst[MAXC], iTick[MAXC], iDone[MAXC];
  logic [8:0] iFF[MAXC], iFE[MAXC];
  logic [4:0] iUS[MAXC], iES[MAXC];
  // Expected-event timeline
  bit         eStart[MAXC], eAck[MAXC], eSD[MAXC], eTO[MAXC], eBusy[MAXC];
  bit         eOvr[MAXC], eRstEff[MAXC], evF[MAXC], evE[MAXC], fUpd[MAXC];
  logic [3:0] evFIdx[MAXC], evEIdx[MAXC];
  logic [8:0] fUpdF[MAXC], fUpdE[MAXC];

  int total = 0, bad = 0, curC = -1, startSeen = 0;

  // Held expectations
  logic       hS = 1'b0, hOvr = 1'b0;
  logic [3:0] hI = '0, hA = '0;
  logic [8:0] hFF = '0, hFE = 9'd511;

  // Tick at cycle t; Done rises n cycles after Start and stays up h cycles
  // past Ack (h >= TO means DRAIN times out). noDone: BattleFront hangs.
  task automatic planStep(input int t, input int n, input int h, input bit noDone,
                          input logic [8:0] ff, input logic [8:0] fe,
                          input logic [4:0] us, input logic [4:0] es);
    int endC, aF;
    iTick[t] = 1'b1;
    eStart[t+1] = 1'b1;
    if (noDone) begin
      endC = t + 2 + TO;
      eTO[endC] = 1'b1;
    end else begin
      for (int c = t; c <= t + n + 2 + h; c++) begin
        iFF[c] = ff; iFE[c] = fe; iUS[c] = us; iES[c] = es;
        if (c >= t + 1 + n) iDone[c] = 1'b1;
      end
      eAck[t+n+2] = 1'b1;
      if (h >= TO) begin
        endC = t + n + 3 + TO;
        eTO[endC] = 1'b1;
      end else begin
        aF = t + n + 4 + h;
        evF[aF] = !us[4];   evFIdx[aF] = us[3:0];
        evE[aF+1] = !es[4]; evEIdx[aF+1] = es[3:0];
        endC = aF + 2;
        fUpd[endC+1] = 1'b1; fUpdF[endC+1] = ff; fUpdE[endC+1] = fe;
      end
    end
    eSD[endC] = 1'b1;
    for (int c = t + 1; c <= endC; c++) eBusy[c] = 1'b1;
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  initial begin
    for (int c = 0; c < MAXC; c++) begin
      iFF[c] = '0; iFE[c] = '0; iUS[c] = '0; iES[c] = '0;
    end
    iRst[0] = 1'b1; iRst[1] = 1'b1; eRstEff[1] = 1'b1; eRstEff[2] = 1'b1;
    planStep(5,   2, 0,  1'b0, 9'd58,  9'd487, 5'd16, 5'd16); // no targets
    planStep(20,  3, 0,  1'b0, 9'd474, 9'd39,  5'd14, 5'd1);  // both strobes
    planStep(35,  0, 0,  1'b1, 9'd0,   9'd0,   5'd0,  5'd0);  // hung WAIT_DONE
    planStep(110, 4, 70, 1'b0, 9'd1,   9'd2,   5'd3,  5'd4);  // hung DRAIN
    planStep(200, 10, 0, 1'b0, 9'd100, 9'd200, 5'd3,  5'd7);  // with overrun
    iTick[205] = 1'b1; eOvr[206] = 1'b1;
    iTick[230] = 1'b1; eStart[231] = 1'b1;                    // reset mid-wait
    for (int c = 231; c <= 240; c++) eBusy[c] = 1'b1;
    iRst[240] = 1'b1; eRstEff[241] = 1'b1;
    planStep(250, 3, 0, 1'b0, 9'd10, 9'd20, 5'd0,  5'd15);
    planStep(265, 3, 0, 1'b0, 9'd11, 9'd21, 5'd16, 5'd2);
    planStep(280, 3, 0, 1'b0, 9'd12, 9'd22, 5'd5,  5'd16);
    planStep(295, 0, 0, 1'b1, 9'd0,  9'd0,  5'd0,  5'd0);

    for (int c = 0; c < MAXC; c++) begin
      @(posedge clk); #1;
      curC = c;
      rst = iRst[c]; Tick = iTick[c]; bf_Done = iDone[c];
      friendlyFront = iFF[c]; enemyFront = iFE[c];
      unitDamageSelect = iUS[c]; enemyDamageSelect = iES[c];
    end
    @(posedge clk); #1;
`ifdef BATTLE_STEP_STATS_EN
    lit("step_count", 32'(step_count), 32'd3);
    lit("abort_count", 32'(abort_count), 32'd1);
    lit("last_latency", 32'(last_latency), 32'd3);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  always @(negedge clk) begin
    if (curC >= 0) begin
      automatic int c = curC;
      automatic logic [33:0] expV, gotV;
      if (eRstEff[c]) begin
        hS = 1'b0; hI = '0; hA = '0; hFF = '0; hFE = 9'd511; hOvr = 1'b0;
      end
      if (eOvr[c]) hOvr = 1'b1;
      if (evF[c]) begin hS = 1'b0; hI = evFIdx[c]; hA = 4'd3; end
      if (evE[c]) begin hS = 1'b1; hI = evEIdx[c]; hA = 4'd3; end
      if (fUpd[c]) begin hFF = fUpdF[c]; hFE = fUpdE[c]; end
      expV = {evF[c] | evE[c], hS, hI, hA, eStart[c], eAck[c], eSD[c], eTO[c],
              eBusy[c], hOvr, hFF, hFE};
      gotV = {dmg_valid, dmg_side, dmg_index, dmg_amount, bf_Start, bf_Ack,
              StepDone, Timeout, Busy, Overrun, front_f, front_e};
      total++;
      if (gotV !== expV) begin
        bad++;
        $display("FAIL cycle %0d outputs: got %h want %h", c, gotV, expV);
      end
      if (c >= 200 && c <= 229 && bf_Start) startSeen++;
      case (c)
        3:   lit("reset fronts/busy", {Busy, front_f, front_e}, {1'b0, 9'd0, 9'd511});
        14:  lit("no-target fronts", {front_f, front_e}, {9'd58, 9'd487});
        27:  lit("friendly strobe", {dmg_valid, dmg_side, dmg_index, dmg_amount}, {1'b1, 1'b0, 4'd14, 4'd3});
        28:  lit("enemy strobe", {dmg_valid, dmg_side, dmg_index, dmg_amount}, {1'b1, 1'b1, 4'd1, 4'd3});
        29:  lit("normal stepdone", {StepDone, Timeout}, 2'b10);
        30:  lit("updated fronts", {front_f, front_e}, {9'd474, 9'd39});
        101: lit("wait abort", {StepDone, Timeout, bf_Ack}, 3'b110);
        102: lit("fronts kept", {front_f, front_e}, {9'd474, 9'd39});
        181: lit("drain abort", {StepDone, Timeout, dmg_valid}, 3'b110);
        206: lit("overrun set", 32'(Overrun), 32'd1);
        229: lit("single start", 32'(startSeen), 32'd1);
        241: lit("mid-step reset", {Overrun, Busy, front_e}, {1'b0, 1'b0, 9'd511});
        default: ;
      endcase
    end
  end
endmodule
